cmp_monitor: RTL

CMP_MONITOR -- requirements
Module: cmp_monitor

---
 rtl/cmp_pkg.sv | 17 +
 rtl/sat_cnt.sv | 29 ++
 rtl/cmp_monitor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding and default sizing for the comparator-result monitor.
// Latency: none (types and constants only).
// Backpressure: none.
package cmp_pkg;

    // Monitor FSM states; the encoding is visible on the state output port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRACK  = 2'b01,
        ST_LOCKED = 2'b10,
        ST_ERROR  = 2'b11
    } cmp_state_t;

    localparam int CMP_CNT_W_DEF   = 8;  // default event counter width
    localparam int CMP_RUN_LEN_DEF = 4;  // default eq run length needed to lock

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: saturating up-counter, clears synchronously, holds at all-ones.
// Latency: 1 cycle from inc to updated q.
// Backpressure: none; inc is ignored once saturated, clr wins over inc.
// Ports: clk, rst_n (sync, active-low), inc (count one), clr (zero), q (count).
module sat_cnt
    import cmp_pkg::*;
#(
    parameter int CNT_W = CMP_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {CNT_W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/cmp_monitor.sv
// cmp_monitor: counts gt/eq/lt comparator samples and locks after a run of eq.
// Latency: 1 cycle from accepted sample to counters, lock and lock_pulse.
// Backpressure: in_ready drops only in ERROR (CMP_MONITOR_ERR_EN builds); else always ready.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready handshake, gt/eq/lt flags,
//        clr (sync clear), gt_cnt/eq_cnt/lt_cnt, lock, lock_pulse, err, state.
// Option: define CMP_MONITOR_ERR_EN to trap samples that are not one-hot into ERROR;
//         otherwise flags resolve by priority gt > eq > lt and all-zero is ignored.
module cmp_monitor
    import cmp_pkg::*;
#(
    parameter int CNT_W   = CMP_CNT_W_DEF,
    parameter int RUN_LEN = CMP_RUN_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    input  logic             clr,
    output logic             in_ready,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             lock,
    output logic             lock_pulse,
    output logic             err,
    output logic [1:0]       state
);

    localparam logic [3:0] RUN_TGT = 4'(RUN_LEN);

    cmp_state_t r_state;
    logic [3:0] r_run;
    logic       r_lock;
    logic       r_lock_pulse;
    logic       r_err;

    logic       w_accept;
    logic       w_gt_ev;
    logic       w_eq_ev;
    logic       w_lt_ev;
    logic       w_bad_ev;
    logic [3:0] w_run_nxt;

`ifdef CMP_MONITOR_ERR_EN
    logic w_legal;

    assign in_ready = (r_state != ST_ERROR);
    assign w_accept = in_valid && in_ready;
    assign w_legal  = $onehot({gt, eq, lt});
    assign w_gt_ev  = w_accept && w_legal && gt;
    assign w_eq_ev  = w_accept && w_legal && eq;
    assign w_lt_ev  = w_accept && w_legal && lt;
    assign w_bad_ev = w_accept && !w_legal;
`else
    // Without error trapping, ambiguous flags resolve gt > eq > lt; ERROR is unreachable.
    assign in_ready = 1'b1;
    assign w_accept = in_valid;
    assign w_gt_ev  = w_accept && gt;
    assign w_eq_ev  = w_accept && !gt && eq;
    assign w_lt_ev  = w_accept && !gt && !eq && lt;
    assign w_bad_ev = 1'b0;
`endif

    // Run of consecutive accepted eq samples, pinned at the lock target.
    always_comb begin
        w_run_nxt = r_run;
        if (w_gt_ev || w_lt_ev) begin
            w_run_nxt = '0;
        end else if (w_eq_ev && (r_run != RUN_TGT)) begin
            w_run_nxt = r_run + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_state      <= ST_IDLE;
            r_run        <= '0;
            r_lock       <= 1'b0;
            r_lock_pulse <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_lock_pulse <= 1'b0;
            r_run        <= w_run_nxt;
            case (r_state)
                ST_IDLE, ST_TRACK: begin
                    if (w_bad_ev) begin
                        r_state <= ST_ERROR;
                        r_err   <= 1'b1;
                    end else if (w_eq_ev && (w_run_nxt == RUN_TGT)) begin
                        // Also covers IDLE straight to LOCKED when RUN_LEN is 1.
                        r_state      <= ST_LOCKED;
                        r_lock       <= 1'b1;
                        r_lock_pulse <= 1'b1;
                    end else if (w_gt_ev || w_eq_ev || w_lt_ev) begin
                        r_state <= ST_TRACK;
                    end
                end
                ST_LOCKED: begin
                    if (w_bad_ev) begin
                        r_state <= ST_ERROR;
                        r_lock  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (w_gt_ev || w_lt_ev) begin
                        r_state <= ST_TRACK;
                        r_lock  <= 1'b0;
                    end
                end
                default: begin
                    // ERROR holds until clr or reset.
                    r_state <= ST_ERROR;
                end
            endcase
        end
    end

    sat_cnt #(.CNT_W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_gt_ev),
        .clr   (clr),
        .q     (gt_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_eq_ev),
        .clr   (clr),
        .q     (eq_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_lt_ev),
        .clr   (clr),
        .q     (lt_cnt)
    );

    assign lock       = r_lock;
    assign lock_pulse = r_lock_pulse;
    assign err        = r_err;
    assign state      = r_state;

endmodule
